// File: rtl/control_unit_p.sv
// Microprogrammed control unit: 57-bit microword register fed by an on-chip microstore ROM.
// Optional feature macro CU_STATE_OUT_EN adds o_state (address of the current microword).
module control_unit_p #(
    parameter int AW = 8,
    parameter int MW = 57
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_ir,
    input  logic          i_moc,
    input  logic          i_cond,
    input  logic          i_mls0,
    input  logic          i_mls1,
`ifdef CU_STATE_OUT_EN
    output logic [AW-1:0] o_state,
`else
`endif
    output logic [31:0]   o_ctl
);

    // Next-state modes (N2N0)
    localparam logic [2:0] N_ENC     = 3'b000;
    localparam logic [2:0] N_CR      = 3'b001;
    localparam logic [2:0] N_INC     = 3'b010;
    localparam logic [2:0] N_CR_INC  = 3'b011;
    localparam logic [2:0] N_INC_CR  = 3'b100;
    localparam logic [2:0] N_ENC_CR  = 3'b101;
    localparam logic [2:0] N_CR_ENC  = 3'b110;
    localparam logic [2:0] N_ZERO    = 3'b111;

    localparam logic [2:0] S_MOC  = 3'd0;
    localparam logic [2:0] S_COND = 3'd1;

    localparam logic [1:0] M_ENC  = 2'd0;
    localparam logic [1:0] M_CR   = 2'd1;
    localparam logic [1:0] M_INC  = 2'd2;
    localparam logic [1:0] M_ZERO = 2'd3;

    logic [MW-1:0] r_uword;
    logic [AW-1:0] r_inc;
    logic [AW-1:0] r_addr;

    logic [2:0]    w_n2n0;
    logic          w_inv;
    logic [2:0]    w_ssel;
    logic [AW-1:0] w_cr;
    logic          w_mux;
    logic          w_sts;
    logic [1:0]    w_msel;
    logic [AW-1:0] w_enc;
    logic [AW-1:0] w_addr;
    logic [MW-1:0] w_rom;
    logic          w_unused;

    function automatic logic [56:0] mk(input logic [2:0] n, input logic inv,
                                       input logic [2:0] s, input logic [31:0] ctl,
                                       input logic [7:0] cr);
        return {n, 2'b00, inv, s, 8'h00, ctl, cr};
    endfunction

    assign w_n2n0   = r_uword[56:54];
    assign w_inv    = r_uword[51];
    assign w_ssel   = r_uword[50:48];
    assign w_cr     = r_uword[AW-1:0];
    assign o_ctl    = r_uword[39:8];
    assign w_unused = ^{r_uword[53:52], r_uword[47:40]};

    always_comb begin
        w_mux = 1'b0;
        case (w_ssel)
            3'd0:    w_mux = i_moc;
            3'd1:    w_mux = i_cond;
            3'd2:    w_mux = i_mls0;
            3'd3:    w_mux = i_mls1;
            3'd4:    w_mux = 1'b1;
            default: w_mux = 1'b0;
        endcase
    end

    assign w_sts = w_mux ^ w_inv;

    always_comb begin
        w_msel = M_ZERO;
        case (w_n2n0)
            N_ENC:    w_msel = M_ENC;
            N_CR:     w_msel = M_CR;
            N_INC:    w_msel = M_INC;
            N_CR_INC: w_msel = w_sts ? M_CR  : M_INC;
            N_INC_CR: w_msel = w_sts ? M_INC : M_CR;
            N_ENC_CR: w_msel = w_sts ? M_ENC : M_CR;
            N_CR_ENC: w_msel = w_sts ? M_CR  : M_ENC;
            N_ZERO:   w_msel = M_ZERO;
            default:  w_msel = M_ZERO;
        endcase
    end

    // Instruction decoder; priority order matters, undefined encodings refetch
    always_comb begin
        w_enc = AW'(1);
        if (i_ir[27:25] == 3'b000 && !i_ir[4] && i_ir[24:23] != 2'b10)
            w_enc = AW'(10);
        else if (i_ir[27:25] == 3'b001 && i_ir[24:23] != 2'b10)
            w_enc = AW'(11);
        else if (i_ir[27:25] == 3'b000 && !i_ir[4] && i_ir[24:23] == 2'b10)
            w_enc = AW'(14);
        else if (i_ir[27:25] == 3'b001 && i_ir[24:23] == 2'b10)
            w_enc = AW'(15);
        else if (i_ir[27:25] == 3'b010)
            w_enc = AW'(20);
        else if (i_ir[27:25] == 3'b011)
            w_enc = AW'(21);
        else if (i_ir[27:25] == 3'b101)
            w_enc = AW'(30);
    end

    assign w_addr = (w_msel == M_ENC) ? w_enc :
                    (w_msel == M_CR)  ? w_cr  :
                    (w_msel == M_INC) ? r_inc : '0;

    // Microstore contents; CTL constants are the datapath signal assignments per state
    always_comb begin
        w_rom = MW'(mk(N_ZERO, 1'b0, 3'd0, 32'h0000_0000, 8'd0));
        case (w_addr)
            AW'(0):  w_rom = MW'(mk(N_CR,     1'b0, 3'd0,   32'h8000_0001, 8'd1));
            AW'(1):  w_rom = MW'(mk(N_INC,    1'b0, 3'd0,   32'h0000_1002, 8'd0));
            AW'(2):  w_rom = MW'(mk(N_INC_CR, 1'b0, S_MOC,  32'h0000_2004, 8'd2));
            AW'(3):  w_rom = MW'(mk(N_INC,    1'b0, 3'd0,   32'h0000_4008, 8'd0));
            AW'(4):  w_rom = MW'(mk(N_ENC_CR, 1'b0, S_COND, 32'h0000_8010, 8'd1));
            AW'(10): w_rom = MW'(mk(N_CR,     1'b0, 3'd0,   32'h0001_000A, 8'd1));
            AW'(11): w_rom = MW'(mk(N_CR,     1'b0, 3'd0,   32'h0002_000B, 8'd1));
            AW'(14): w_rom = MW'(mk(N_CR,     1'b0, 3'd0,   32'h0004_000E, 8'd1));
            AW'(15): w_rom = MW'(mk(N_CR,     1'b0, 3'd0,   32'h0008_000F, 8'd1));
            AW'(20): w_rom = MW'(mk(N_CR,     1'b0, 3'd0,   32'h0010_0014, 8'd1));
            AW'(21): w_rom = MW'(mk(N_CR,     1'b0, 3'd0,   32'h0020_0015, 8'd1));
            AW'(30): w_rom = MW'(mk(N_CR,     1'b0, 3'd0,   32'h0040_001E, 8'd1));
            default: w_rom = MW'(mk(N_ZERO,   1'b0, 3'd0,   32'h0000_0000, 8'd0));
        endcase
    end

    // Reset loads word 0 directly so CTL is valid without a clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_uword <= MW'(mk(N_CR, 1'b0, 3'd0, 32'h8000_0001, 8'd1));
            r_inc   <= AW'(1);
            r_addr  <= '0;
        end else begin
            r_uword <= w_rom;
            r_inc   <= w_addr + AW'(1);
            r_addr  <= w_addr;
        end
    end

`ifdef CU_STATE_OUT_EN
    assign o_state = r_addr;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^r_addr;
`endif

endmodule

// File: tb/tb_control_unit_p.sv
// Directed bench for control_unit_p: states are identified by their CTL word.
module tb_control_unit_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        moc = 1'b0;
    logic        cond = 1'b0;
    logic        mls0 = 1'b0;
    logic        mls1 = 1'b0;
    logic [31:0] ctl;
`ifdef CU_STATE_OUT_EN
    logic [7:0]  state;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] C0  = 32'h8000_0001;
    localparam logic [31:0] C1  = 32'h0000_1002;
    localparam logic [31:0] C2  = 32'h0000_2004;
    localparam logic [31:0] C3  = 32'h0000_4008;
    localparam logic [31:0] C4  = 32'h0000_8010;
    localparam logic [31:0] C10 = 32'h0001_000A;
    localparam logic [31:0] C11 = 32'h0002_000B;
    localparam logic [31:0] C14 = 32'h0004_000E;
    localparam logic [31:0] C15 = 32'h0008_000F;
    localparam logic [31:0] C20 = 32'h0010_0014;
    localparam logic [31:0] C21 = 32'h0020_0015;
    localparam logic [31:0] C30 = 32'h0040_001E;

    control_unit_p dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ir    (ir),
        .i_moc   (moc),
        .i_cond  (cond),
        .i_mls0  (mls0),
        .i_mls1  (mls1),
`ifdef CU_STATE_OUT_EN
        .o_state (state),
`endif
        .o_ctl   (ctl)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        moc = 1'b0; cond = 1'b0; mls0 = 1'b0; mls1 = 1'b0; ir = 32'h0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic reach_state4();
        do_reset();
        moc = 1'b1;
        ir = 32'hEE00_0000;
        for (int i = 0; i < 4; i++) begin
            ir = ir ^ 32'h0200_0000;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ctl !== C0) begin failures++; $display("FAIL reset_ctl got=%h exp=%h", ctl, C0); end
        checks++; if (dut.r_inc !== 8'd1) begin failures++; $display("FAIL reset_inc got=%0d exp=1", dut.r_inc); end
`ifdef CU_STATE_OUT_EN
        checks++; if (state !== 8'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
`endif
        step();
        checks++; if (ctl !== C1) begin failures++; $display("FAIL reset_s1 got=%h exp=%h", ctl, C1); end
        step();
        checks++; if (ctl !== C2) begin failures++; $display("FAIL reset_s2 got=%h exp=%h", ctl, C2); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (ctl !== C2) begin failures++; $display("FAIL moc_hold%0d got=%h exp=%h", i, ctl, C2); end
        end
    endtask

    task automatic test_moc_decode();
        moc = 1'b1;
        step();
        checks++; if (ctl !== C3) begin failures++; $display("FAIL moc_s3 got=%h exp=%h", ctl, C3); end
        step();
        checks++; if (ctl !== C4) begin failures++; $display("FAIL moc_s4 got=%h exp=%h", ctl, C4); end
        ir = 32'hE1D4_5004; cond = 1'b1;
        step();
        checks++; if (ctl !== C10) begin failures++; $display("FAIL dec_s10 got=%h exp=%h", ctl, C10); end
        step();
        checks++; if (ctl !== C1) begin failures++; $display("FAIL dec_back1 got=%h exp=%h", ctl, C1); end
    endtask

    task automatic test_decode_table();
        logic [31:0] irs [8] = '{32'hF29A_102C, 32'hF13A_102C, 32'hF31A_102C, 32'hE590_0000,
                                 32'hE790_0000, 32'hEA00_0000, 32'hEE00_0000, 32'hE000_0010};
        logic [31:0] exps [8] = '{C11, C14, C15, C20, C21, C30, C1, C1};
        for (int k = 0; k < 8; k++) begin
            reach_state4();
            checks++; if (ctl !== C4) begin failures++; $display("FAIL tbl%0d_s4 got=%h exp=%h", k, ctl, C4); end
            ir = irs[k]; cond = 1'b1;
            step();
            checks++; if (ctl !== exps[k]) begin failures++; $display("FAIL tbl%0d_ir%h got=%h exp=%h", k, irs[k], ctl, exps[k]); end
        end
    endtask

    task automatic test_cond_fail();
        reach_state4();
        ir = 32'hEA00_0000; cond = 1'b0;
        step();
        checks++; if (ctl !== C1) begin failures++; $display("FAIL cond0_refetch got=%h exp=%h", ctl, C1); end
        step();
        checks++; if (ctl !== C2) begin failures++; $display("FAIL cond0_s2 got=%h exp=%h", ctl, C2); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        step(); step(); step();
        checks++; if (ctl !== C2) begin failures++; $display("FAIL mid_pre got=%h exp=%h", ctl, C2); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ctl !== C0) begin failures++; $display("FAIL mid_async_ctl got=%h exp=%h", ctl, C0); end
        checks++; if (dut.r_inc !== 8'd1) begin failures++; $display("FAIL mid_async_inc got=%0d exp=1", dut.r_inc); end
        step();
        checks++; if (ctl !== C0) begin failures++; $display("FAIL mid_held got=%h exp=%h", ctl, C0); end
        rst_n = 1'b1;
        step();
        checks++; if (ctl !== C1) begin failures++; $display("FAIL mid_release got=%h exp=%h", ctl, C1); end
    endtask

    task automatic test_unlisted_jump();
        do_reset();
        step();
        force dut.w_addr = 8'd200;
        step();
        checks++; if (ctl !== 32'h0) begin failures++; $display("FAIL s200_ctl got=%h exp=0", ctl); end
`ifdef CU_STATE_OUT_EN
        checks++; if (state !== 8'd200) begin failures++; $display("FAIL s200_state got=%0d exp=200", state); end
`endif
        release dut.w_addr;
        step();
        checks++; if (ctl !== C0) begin failures++; $display("FAIL s200_to0 got=%h exp=%h", ctl, C0); end
        step();
        checks++; if (ctl !== C1) begin failures++; $display("FAIL s200_to1 got=%h exp=%h", ctl, C1); end
    endtask

    initial begin
        test_reset();
        test_moc_decode();
        test_decode_table();
        test_cond_fail();
        test_reset_mid_wait();
        test_unlisted_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
